// File: rtl/snn_pkg.sv
// Shared types and helpers for the spiking front end (encoder FSM state, counter sizing).
package snn_pkg;

  typedef enum logic [0:0] {
    ENC_IDLE = 1'b0,
    ENC_RUN  = 1'b1
  } enc_state_e;

  // Bits needed to count 0..window inclusive.
  function automatic int step_cnt_w(input int window);
    return $clog2(window + 1);
  endfunction

endpackage

// File: rtl/spike_encoder_ch.sv
// One rate-coding channel: latched intensity, wrapping accumulator, carry-out spike.
// Spike registered one cycle after its tick; no backpressure, load/clear take priority over tick.
module spike_encoder_ch #(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic              tick_i,
  input  logic [DATA_W-1:0] sample_i,
  output logic              axon_o
);

  logic [DATA_W-1:0] sample_q, sample_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              axon_q, axon_d;
  logic [DATA_W:0]   sum;

  // The carry out of the wrapping add is the spike.
  assign sum = {1'b0, acc_q} + {1'b0, sample_q};

  always_comb begin
    sample_d = sample_q;
    acc_d    = acc_q;
    axon_d   = 1'b0;
    if (load_i) sample_d = sample_i;
    if (clear_i) begin
      acc_d = '0;
    end else if (tick_i) begin
      acc_d  = sum[DATA_W-1:0];
      axon_d = sum[DATA_W];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sample_q <= '0;
      acc_q    <= '0;
      axon_q   <= 1'b0;
    end else begin
      sample_q <= sample_d;
      acc_q    <= acc_d;
      axon_q   <= axon_d;
    end
  end

  assign axon_o = axon_q;

endmodule

// File: rtl/spike_encoder.sv
// Rate-coding spike source: accepts one sample vector, emits WINDOW ticks of spike trains.
// Axon pulses one cycle after each tick; ready_o low for the whole window (upstream holds).
module spike_encoder
  import snn_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int WINDOW = 100
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_CH*DATA_W-1:0] sample_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic                     tick_i,
  output logic [NUM_CH-1:0]        axon_o,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam int CNT_W = step_cnt_w(WINDOW);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW - 1);

  enc_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;
  logic             accept;
  logic             tick_run;

  assign accept   = valid_i && (state_q == ENC_IDLE);
  assign tick_run = tick_i && (state_q == ENC_RUN);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ENC_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ENC_IDLE: begin
          if (valid_i) begin
            cnt_q   <= '0;
            state_q <= ENC_RUN;
          end
        end
        ENC_RUN: begin
          if (tick_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
            // Window closes on the tick itself so a new sample can land next cycle.
            if (cnt_q == LAST_CNT) begin
              state_q <= ENC_IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= ENC_IDLE;
      endcase
    end
  end

  assign ready_o = (state_q == ENC_IDLE);
  assign busy_o  = (state_q == ENC_RUN);
  assign done_o  = done_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    spike_encoder_ch #(
      .DATA_W(DATA_W)
    ) u_ch (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .load_i  (accept),
      .clear_i (accept),
      .tick_i  (tick_run),
      .sample_i(sample_i[c*DATA_W +: DATA_W]),
      .axon_o  (axon_o[c])
    );
  end

endmodule

// File: tb/tb_spike_encoder.sv
// Directed bench for spike_encoder: spike-count model checked every cycle plus literal spot checks.
module tb_spike_encoder;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 8;
  localparam int WINDOW = 100;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  logic [NUM_CH*DATA_W-1:0] sample_i = '0;
  logic                     valid_i  = 1'b0;
  logic                     tick_i   = 1'b0;
  logic                     ready_o, busy_o, done_o;
  logic [NUM_CH-1:0]        axon_o;

  logic [NUM_CH*DATA_W-1:0] w1_sample = '0;
  logic                     w1_valid  = 1'b0;
  logic                     w1_tick   = 1'b0;
  logic                     w1_ready, w1_busy, w1_done;
  logic [NUM_CH-1:0]        w1_axon;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Model state: latched intensities, ticks processed in this window, window active.
  int m_s [NUM_CH];
  int m_k;
  bit m_run;
  logic [NUM_CH-1:0] exp_axon;
  logic exp_done, exp_ready, exp_busy;

  int spk [NUM_CH];
  int busy_cyc;

  always #5 clk = ~clk;

  spike_encoder #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .WINDOW(WINDOW)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .sample_i(sample_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .tick_i  (tick_i),
    .axon_o  (axon_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  spike_encoder #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .WINDOW(1)) dut_w1 (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .sample_i(w1_sample),
    .valid_i (w1_valid),
    .ready_o (w1_ready),
    .tick_i  (w1_tick),
    .axon_o  (w1_axon),
    .busy_o  (w1_busy),
    .done_o  (w1_done)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tally();
    for (int c = 0; c < NUM_CH; c++) spk[c] += int'(axon_o[c]);
    busy_cyc += int'(busy_o);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Spike count after k ticks is floor(k*s/2^DATA_W); a spike appears on tick k
  // exactly when that floor steps up.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run     <= 1'b0;
      m_k       <= 0;
      exp_axon  <= '0;
      exp_done  <= 1'b0;
      exp_ready <= 1'b1;
      exp_busy  <= 1'b0;
    end else begin
      exp_axon  <= '0;
      exp_done  <= 1'b0;
      exp_ready <= !m_run;
      exp_busy  <= m_run;
      if (!m_run) begin
        if (valid_i) begin
          for (int c = 0; c < NUM_CH; c++) m_s[c] <= int'(sample_i[c*DATA_W +: DATA_W]);
          m_k       <= 0;
          m_run     <= 1'b1;
          exp_ready <= 1'b0;
          exp_busy  <= 1'b1;
        end
      end else if (tick_i) begin
        for (int c = 0; c < NUM_CH; c++)
          exp_axon[c] <= (((m_k + 1) * m_s[c]) >> DATA_W) != ((m_k * m_s[c]) >> DATA_W);
        m_k <= m_k + 1;
        if (m_k + 1 == WINDOW) begin
          m_run     <= 1'b0;
          exp_done  <= 1'b1;
          exp_ready <= 1'b1;
          exp_busy  <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("axon_o vs model", int'(axon_o), int'(exp_axon));
      chk("done_o vs model", int'(done_o), int'(exp_done));
      chk("ready_o vs model", int'(ready_o), int'(exp_ready));
      chk("busy_o vs model", int'(busy_o), int'(exp_busy));
      tally();
    end
  end

  // Accept s, run WINDOW ticks spaced 'period' cycles apart, then check the done
  // cycle and the per-channel spike totals against hand-computed counts.
  task automatic run_window(input logic [31:0] s, input int period, input bit poke,
                            input logic [31:0] ecnt, input string tag);
    for (int c = 0; c < NUM_CH; c++) spk[c] = 0;
    busy_cyc = 0;
    sample_i = s;
    valid_i  = 1'b1;
    tick_i   = 1'b0;
    step();
    valid_i = 1'b0;
    for (int i = 0; i < WINDOW * period; i++) begin
      tick_i = ((i + 1) % period) == 0;
      if (poke && i == 10) begin
        valid_i  = 1'b1;
        sample_i = '1;
        #1;
        chk({tag, " ready_o during run"}, int'(ready_o), 0);
      end
      if (poke && i == 11) begin
        valid_i  = 1'b0;
        sample_i = s;
      end
      step();
    end
    tick_i = 1'b0;
    #1;
    chk({tag, " done_o pulse"}, int'(done_o), 1);
    chk({tag, " ready_o in done cycle"}, int'(ready_o), 1);
    @(negedge clk);
    #1;
    for (int c = 0; c < NUM_CH; c++)
      chk($sformatf("%s spike count ch%0d", tag, c), spk[c], int'(ecnt[c*8 +: 8]));
    chk({tag, " busy cycles"}, busy_cyc, WINDOW * period);
  endtask

  initial begin
    // Reset asserted mid-cycle; outputs must clear asynchronously.
    #12;
    rst_n  = 1'b0;
    chk_en = 1'b1;
    #1;
    chk("reset axon_o", int'(axon_o), 0);
    chk("reset ready_o", int'(ready_o), 1);
    chk("reset busy_o", int'(busy_o), 0);
    chk("reset done_o", int'(done_o), 0);
    step();
    step();
    rst_n = 1'b1;

    tick_i = 1'b1;
    repeat (5) step();
    tick_i = 1'b0;
    chk("idle ticks spike-free", int'(axon_o), 0);

    // WINDOW=1 instance: first tick closes the window, s=255 gives no spike yet.
    w1_sample = '1;
    w1_valid  = 1'b1;
    step();
    w1_valid = 1'b0;
    #1;
    chk("w1 busy after accept", int'(w1_busy), 1);
    chk("w1 ready after accept", int'(w1_ready), 0);
    w1_tick = 1'b1;
    step();
    #1;
    chk("w1 axon on first tick", int'(w1_axon), 0);
    chk("w1 done on first tick", int'(w1_done), 1);
    chk("w1 ready in done cycle", int'(w1_ready), 1);
    chk("w1 busy in done cycle", int'(w1_busy), 0);
    step();
    #1;
    chk("w1 done single pulse", int'(w1_done), 0);
    chk("w1 idle tick no spike", int'(w1_axon), 0);
    w1_tick = 1'b0;

    // Channels {0,64,128,255}, continuous ticks -> {0,25,50,99} spikes.
    run_window(32'hFF80_4000, 1, 1'b0, 32'h6332_1900, "rate");
    step();
    step();

    // s=128 everywhere, tick every third cycle -> 50 spikes, 300 busy cycles.
    run_window(32'h8080_8080, 3, 1'b0, 32'h3232_3232, "sparse");
    step();

    // Valid poked during RUN is ignored; next sample offered in the done cycle.
    run_window(32'hFF80_4000, 1, 1'b1, 32'h6332_1900, "handshake");
    run_window(32'h40C8_01FF, 1, 1'b0, 32'h194E_0063, "back-to-back");
    step();

    // Abort after 40 ticks; a following window must produce full counts.
    sample_i = 32'hFF80_4000;
    valid_i  = 1'b1;
    step();
    valid_i = 1'b0;
    tick_i  = 1'b1;
    repeat (40) step();
    tick_i = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("abort axon_o", int'(axon_o), 0);
    chk("abort busy_o", int'(busy_o), 0);
    chk("abort ready_o", int'(ready_o), 1);
    chk("abort done_o", int'(done_o), 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    run_window(32'hFF80_4000, 1, 1'b0, 32'h6332_1900, "after abort");
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spike_encoder.md
# spike_encoder

Rate-coding spike source that turns a vector of input intensities into per-channel axon spike trains for the neuron array. It accepts one sample vector through a valid/ready handshake, then emits deterministic spike trains for a fixed window of timesteps. The spike trains drive the neurons' axon inputs: one wire per channel, and each pulse is one clock wide. It sits between the input-sample source and the first neuron layer.

## Interface
- NUM_CH, 4: number of channels, which is also the number of axon outputs.
- DATA_W, 8: width of each intensity value (unsigned).
- WINDOW, 100: number of timesteps per sample. Legal range is 1 and above.
- clk_i, input, 1: the single clock.
- rst_ni, input, 1: asynchronous, active-low reset.
- sample_i, input, NUM_CH*DATA_W: intensity vector. Channel c occupies bits [c*DATA_W +: DATA_W].
- valid_i, input, 1: sample_i is valid.
- ready_o, output, 1: encoder can accept a sample.
- tick_i, input, 1: timestep strobe, one clock wide. It may be asserted every cycle.
- axon_o, output, NUM_CH: spike outputs, registered.
- busy_o, output, 1: a window is in progress.
- done_o, output, 1: one-cycle pulse when the window completes.

## Operation
- Two-state FSM: IDLE and RUN.
- **IDLE**
  - ready_o=1 and busy_o=0.
  - On valid_i && ready_o: latch sample_i, clear all accumulators and the step counter, then go to RUN.
  - tick_i is ignored.
- **RUN**
  - ready_o=0 and busy_o=1. valid_i is ignored and the sample is held upstream.
- **Per-channel accumulator** (each tick_i in RUN):
  - Accumulator is DATA_W bits, unsigned.
  - sum = {1'b0, acc} + {1'b0, s}, which is DATA_W+1 bits.
  - axon_o[c] is registered from sum[DATA_W], the carry.
  - acc takes sum[DATA_W-1:0], so wrap-around is intended.
- **Spike count:** after k ticks, the spikes emitted on channel c equal floor(k*s_c / 2^DATA_W). The train is deterministic; there is no randomness.
- s=0 never spikes. s=2^DATA_W-1 spikes on every tick except the first.
- **Step counter:** $clog2(WINDOW+1) bits, incremented on each tick in RUN. When the WINDOW-th tick is processed:
  - the FSM returns to IDLE on the next edge;
  - done_o pulses for that one cycle.
- On cycles without a processed tick, axon_o=0.

## Timing
- Reset (rst_ni low, asynchronous):
  - state goes to IDLE; accumulators, counter, latched sample, axon_o, busy_o and done_o go to 0.
  - ready_o=1 while in reset and after release.
- Accept at edge N, so RUN starts from N+1. A tick_i coincident with the accepting cycle is ignored.
- Latency: tick_i sampled at edge M produces axon_o at cycle M+1, for exactly one cycle.
- Final tick at edge M gives, in cycle M+1:
  - the last axon_o;
  - done_o=1;
  - state IDLE, so ready_o=1 and busy_o=0.
- A valid_i in cycle M+1 is accepted at edge M+2. Back-to-back samples therefore lose zero ticks except the one in the accepting cycle.
- Reset in mid-window: the window is aborted, done_o is not pulsed, and no residual spikes appear.
- WINDOW=1: the first tick in RUN completes the window.

## Structure
- snn_pkg holds:
  - the FSM enum type enc_state_e {ENC_IDLE, ENC_RUN};
  - a shared function for the counter width.
- Sub-module spike_encoder_ch: one channel's sample register, accumulator and carry output, with ports for load, tick and clear. It is instantiated NUM_CH times in a generate loop.
- The top level holds the FSM, the step counter and the handshake.

## Test plan
- Reset then idle: hold rst_ni low mid-cycle, then release. Expect axon_o=0, ready_o=1, busy_o=0 and done_o=0. Ticks in IDLE must produce no spikes.
- Rate accuracy: with defaults, sample {0, 64, 128, 255} and 100 consecutive ticks (tick_i tied high). Expected spike counts are {0, 25, 50, 99}, with a single done_o pulse one cycle after the 100th tick.
- Sparse ticks: s=128 with ticks every 3rd cycle. Expect channel spikes on alternate ticks, each 1 cycle wide and 1 cycle after its tick, and busy_o for the full 300-cycle span.
- Handshake: assert valid_i during RUN. Expect ready_o=0 and the sample not taken. Then assert valid_i in the done_o cycle: expect acceptance at the next edge and a fresh window with the accumulators cleared.
- Mid-window reset: pulse rst_ni low after 40 ticks. Expect immediate IDLE, no done_o, and axon_o=0. A new sample must then give full-window counts.
- Edge parameters: WINDOW=1, DATA_W=8, s=255. The first tick yields axon_o=0 and done_o=1 in the same cycle.
